prio_gnt_sched_w8: RTL and testbench

PRIO_GNT_SCHED_W8 -- requirements
Module: prio_gnt_sched_w8

---
 rtl/prio_sched_pkg.sv | 31 +++
 rtl/prio_enc_w8_t2.sv | 59 +++++
 rtl/prio_gnt_sched_w8.sv | 100 ++++++++++
 tb/tb_prio_gnt_sched_w8.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/prio_sched_pkg.sv
// ---------------------------------------------------------------------------
// prio_sched_pkg -- shared constants, FSM state type and encode helper.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package prio_sched_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int ENC_W   = 4;

  localparam logic [ENC_W-1:0] ENC_NONE = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_WAIT2 = 2'd2,
    ST_OFFER = 2'd3
  } state_t;

  function automatic logic [ENC_W-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
    lowest_set = ENC_NONE;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = ENC_W'(i);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/prio_enc_w8_t2.sv
// ---------------------------------------------------------------------------
// prio_enc_w8_t2 -- lowest-set-bit encoder, 8 -> 4 (8 = none); pipelined, the
// consumer's capture register forms the second stage. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prio_enc_w8_t2
  import prio_sched_pkg::*;
#(
  parameter logic SIM_EMULATE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] din,
  output logic [ENC_W-1:0]   dout
);

  logic [ENC_W-1:0] enc_comb;
  logic [ENC_W-1:0] enc_r;

  generate
    if (SIM_EMULATE) begin : g_emul
      always_comb enc_comb = lowest_set(din);
    end else begin : g_tree
      logic       lo_any;
      logic       hi_any;
      logic [1:0] lo_idx;
      logic [1:0] hi_idx;

      // Two nibble encoders merged; the low nibble always wins.
      always_comb begin
        lo_any = |din[3:0];
        hi_any = |din[7:4];
        lo_idx = din[0] ? 2'd0 : din[1] ? 2'd1 : din[2] ? 2'd2 : 2'd3;
        hi_idx = din[4] ? 2'd0 : din[5] ? 2'd1 : din[6] ? 2'd2 : 2'd3;
        if (lo_any) begin
          enc_comb = {2'b00, lo_idx};
        end else if (hi_any) begin
          enc_comb = {2'b01, hi_idx};
        end else begin
          enc_comb = ENC_NONE;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_r <= ENC_NONE;
    end else begin
      enc_r <= enc_comb;
    end
  end

  assign dout = enc_r;

endmodule

`default_nettype wire

// File: rtl/prio_gnt_sched_w8.sv
// ---------------------------------------------------------------------------
// prio_gnt_sched_w8 -- pending-request register with lowest-index grant FSM.
// Optional req_mask port with PRIO_GNT_SCHED_MASK_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prio_gnt_sched_w8
  import prio_sched_pkg::*;
#(
  parameter logic SIM_EMULATE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_set,
`ifdef PRIO_GNT_SCHED_MASK_EN
  input  logic [NUM_REQ-1:0] req_mask,
`endif
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  input  logic               gnt_ready,
  output logic [NUM_REQ-1:0] pend,
  output logic               busy
);

  state_t               state;
  state_t               state_nxt;
  logic [NUM_REQ-1:0]   pend_r;
  logic [NUM_REQ-1:0]   snap_r;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   clr;
  logic [ENC_W-1:0]     enc_dout;
  logic [IDX_W-1:0]     gnt_idx_r;
  logic                 load_snap;
  logic                 load_gnt;
  logic                 accept;

`ifdef PRIO_GNT_SCHED_MASK_EN
  assign eligible = pend_r & ~req_mask;
`else
  assign eligible = pend_r;
`endif

  prio_enc_w8_t2 #(
    .SIM_EMULATE (SIM_EMULATE)
  ) u_enc (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (snap_r),
    .dout  (enc_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (|eligible) state_nxt = ST_WAIT1;
      ST_WAIT1: state_nxt = ST_WAIT2;
      // An empty encode cannot happen since snap_r is only loaded non-zero.
      ST_WAIT2: state_nxt = (enc_dout == ENC_NONE) ? ST_IDLE : ST_OFFER;
      ST_OFFER: if (gnt_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    gnt_valid = (state == ST_OFFER);
    load_snap = (state == ST_IDLE) && (|eligible);
    load_gnt  = (state == ST_WAIT2) && (enc_dout != ENC_NONE);
    accept    = gnt_valid && gnt_ready;
  end

  assign clr = accept ? (NUM_REQ'(1) << gnt_idx_r) : '0;

  // OR-ing req_set last gives a same-cycle set priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r    <= '0;
      snap_r    <= '0;
      gnt_idx_r <= '0;
    end else begin
      pend_r <= (pend_r & ~clr) | req_set;
      if (load_snap) snap_r <= eligible;
      if (load_gnt) gnt_idx_r <= enc_dout[IDX_W-1:0];
    end
  end

  assign pend    = pend_r;
  assign gnt_idx = gnt_idx_r;

endmodule

`default_nettype wire

// File: tb/tb_prio_gnt_sched_w8.sv
// ---------------------------------------------------------------------------
// tb_prio_gnt_sched_w8 -- directed self-checking bench for prio_gnt_sched_w8.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prio_gnt_sched_w8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_set = 8'h00;
  logic       gnt_ready = 1'b0;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] pend;
  logic       busy;
`ifdef PRIO_GNT_SCHED_MASK_EN
  logic [7:0] req_mask = 8'h00;
`endif

  int errors = 0;
  int checks = 0;

  prio_gnt_sched_w8 #(
    .SIM_EMULATE (1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_set   (req_set),
`ifdef PRIO_GNT_SCHED_MASK_EN
    .req_mask  (req_mask),
`endif
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt_ready (gnt_ready),
    .pend      (pend),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Pulse req_set for one cycle; returns at cycle 1 of the sequence.
  task automatic pulse(input logic [7:0] v);
    req_set = v;
    tick();
    req_set = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_valid", {7'd0, gnt_valid}, 8'h00);
    chk("rst_idx",   {5'd0, gnt_idx},   8'h00);
    chk("rst_pend",  pend,              8'h00);
    chk("rst_busy",  {7'd0, busy},      8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // Single request: grant idx 5 at cycle 4
    pulse(8'h20);
    chk("s_pend_c1", pend, 8'h20);
    chk("s_busy_c1", {7'd0, busy}, 8'h00);
    tick();
    chk("s_busy_c2", {7'd0, busy}, 8'h01);
    tick();
    chk("s_valid_c3", {7'd0, gnt_valid}, 8'h00);
    tick();
    chk("s_valid_c4", {7'd0, gnt_valid}, 8'h01);
    chk("s_idx_c4",   {5'd0, gnt_idx},   8'h05);
    gnt_ready = 1'b1;
    tick();
    gnt_ready = 1'b0;
    chk("s_pend_done",  pend, 8'h00);
    chk("s_valid_done", {7'd0, gnt_valid}, 8'h00);
    chk("s_busy_done",  {7'd0, busy}, 8'h00);

    // Priority order 2,5,7 with gnt_ready held high, grants 4 cycles apart
    gnt_ready = 1'b1;
    pulse(8'hA4);
    for (int c = 1; c <= 13; c++) begin
      chk($sformatf("p_valid_c%0d", c), {7'd0, gnt_valid},
          (c == 4 || c == 8 || c == 12) ? 8'h01 : 8'h00);
      if (c == 4)  chk("p_idx_1st", {5'd0, gnt_idx}, 8'h02);
      if (c == 8)  chk("p_idx_2nd", {5'd0, gnt_idx}, 8'h05);
      if (c == 12) chk("p_idx_3rd", {5'd0, gnt_idx}, 8'h07);
      if (c == 5)  chk("p_pend_c5", pend, 8'hA0);
      if (c < 13) tick();
    end
    chk("p_pend_end", pend, 8'h00);
    gnt_ready = 1'b0;
    tick();

    // Stall with a lower-index arrival during OFFER: no preemption
    pulse(8'h80);
    ticks(3);
    chk("n_valid_c4", {7'd0, gnt_valid}, 8'h01);
    chk("n_idx_c4",   {5'd0, gnt_idx},   8'h07);
    pulse(8'h01);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("n_hold_idx%0d", c), {4'd0, gnt_valid, gnt_idx}, 8'h0F);
      if (c < 9) tick();
    end
    chk("n_pend_both", pend, 8'h81);
    gnt_ready = 1'b1;
    tick();
    gnt_ready = 1'b0;
    chk("n_pend_after", pend, 8'h01);
    ticks(3);
    chk("n_valid_next", {7'd0, gnt_valid}, 8'h01);
    chk("n_idx_next",   {5'd0, gnt_idx},   8'h00);
    gnt_ready = 1'b1;
    tick();
    gnt_ready = 1'b0;
    chk("n_pend_end", pend, 8'h00);

    // Set/clear collision on bit 3
    pulse(8'h08);
    ticks(3);
    chk("c_idx_1st", {4'd0, gnt_valid, gnt_idx}, 8'h0B);
    req_set = 8'h08;
    gnt_ready = 1'b1;
    tick();
    req_set = 8'h00;
    gnt_ready = 1'b0;
    chk("c_pend_kept", pend, 8'h08);
    chk("c_valid_off", {7'd0, gnt_valid}, 8'h00);
    ticks(3);
    chk("c_idx_again", {4'd0, gnt_valid, gnt_idx}, 8'h0B);
    gnt_ready = 1'b1;
    tick();
    gnt_ready = 1'b0;
    chk("c_pend_end", pend, 8'h00);

    // Reset while in WAIT2 with pend=0F
    pulse(8'h0F);
    ticks(2);
    chk("r_busy_w2", {7'd0, busy}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("r_pend_now",  pend, 8'h00);
    chk("r_busy_now",  {7'd0, busy}, 8'h00);
    chk("r_valid_now", {7'd0, gnt_valid}, 8'h00);
    ticks(2);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (gnt_valid !== 1'b0 || busy !== 1'b0) seen++;
      end
      chk("r_quiet_20", seen[7:0], 8'h00);
    end

    // Reset while offering idx 5: gnt_idx returns to 0 at once
    pulse(8'h20);
    ticks(3);
    chk("r2_idx_pre", {4'd0, gnt_valid, gnt_idx}, 8'h0D);
    rst_n = 1'b0;
    #1;
    chk("r2_idx_now", {4'd0, gnt_valid, gnt_idx}, 8'h00);
    ticks(2);
    rst_n = 1'b1;
    tick();

`ifdef PRIO_GNT_SCHED_MASK_EN
    // Masked bit stays pending but is skipped until the mask drops
    req_mask = 8'h01;
    pulse(8'h03);
    ticks(3);
    chk("m_idx_1", {4'd0, gnt_valid, gnt_idx}, 8'h09);
    gnt_ready = 1'b1;
    tick();
    gnt_ready = 1'b0;
    chk("m_pend_kept", pend, 8'h01);
    ticks(2);
    chk("m_busy_masked", {7'd0, busy}, 8'h00);
    req_mask = 8'h00;
    tick();
    ticks(3);
    chk("m_idx_0", {4'd0, gnt_valid, gnt_idx}, 8'h08);
    gnt_ready = 1'b1;
    tick();
    gnt_ready = 1'b0;
    chk("m_pend_end", pend, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
